flash_read_arbiter: RTL and testbench

FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

---
 rtl/flash_pkg.sv | 18 +
 rtl/rr_arb2.sv | 16 +
 rtl/flash_read_arbiter.sv | 129 ++++++++++++
 tb/tb_flash_read_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and widths for the flash read arbiter.
package flash_pkg;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
    } hit_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);
    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end
endmodule

// File: rtl/flash_read_arbiter.sv
// Two-port flash read arbiter with a one-entry hit register per port and a
// busy-timeout watchdog on the flash handshake.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              flush,
    input  logic              fl_ready,
    output logic              fl_read_en,
    output logic [ADDR_W-1:0] fl_addr,
    input  logic [DATA_W-1:0] fl_rdata,
    output logic              timeout_err
);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [1:0]        req_v;
    logic [1:0]        ack_q;
    logic [1:0]        tag_match;
    logic [1:0]        hit;
    logic [1:0]        pending;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] addr_v [2];
    logic [DATA_W-1:0] rdata_q [2];
    hit_tag_t          tag_q [2];
    logic              gnt_port;
    logic              last_served;
    logic [CNT_W-1:0]  busy_cnt;

    assign req_v     = {req1, req0};
    assign addr_v[0] = addr0;
    assign addr_v[1] = addr1;

    always_comb begin
        tag_match = '0;
        hit       = '0;
        pending   = '0;
        for (int i = 0; i < 2; i++) begin
            tag_match[i] = tag_q[i].valid && (tag_q[i].tag == addr_v[i]);
            // A port is deaf during its own ack cycle so a held request is not served twice.
            hit[i]       = (state == ST_IDLE) && req_v[i] && !ack_q[i] && tag_match[i];
            pending[i]   = req_v[i] && !ack_q[i] && !tag_match[i];
        end
    end

    rr_arb2 u_rr_arb2 (
        .req        (pending),
        .last_served(last_served),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ack_q       <= '0;
            fl_read_en  <= 1'b0;
            fl_addr     <= '0;
            gnt_port    <= 1'b0;
            last_served <= 1'b1;
            busy_cnt    <= '0;
            timeout_err <= 1'b0;
            // NOTE: the per-port data/tag registers are reset because they drive outputs and hit decisions.
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block deliberately override earlier ones.
            ack_q      <= '0;
            fl_read_en <= 1'b0;
            if (flush) begin
                tag_q[0].valid <= 1'b0;
                tag_q[1].valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    ack_q <= hit;
                    if ((pending != 2'b00) && fl_ready) begin
                        gnt_port   <= grant[1];
                        fl_addr    <= grant[0] ? addr0 : addr1;
                        fl_read_en <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    busy_cnt <= '0;
                    state    <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW, ST_WAIT_HIGH: begin
                    busy_cnt <= busy_cnt + 1'b1;
                    if ((state == ST_WAIT_HIGH) && fl_ready) begin
                        // Capture sits after the flush clear, so fresh data stays valid.
                        rdata_q[gnt_port] <= fl_rdata;
                        tag_q[gnt_port]   <= '{valid: 1'b1, tag: fl_addr};
                        ack_q[gnt_port]   <= 1'b1;
                        state             <= ST_RESP;
                    end else if (busy_cnt == BUSY_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if ((state == ST_WAIT_LOW) && !fl_ready) begin
                        state <= ST_WAIT_HIGH;
                    end
                end
                ST_RESP: begin
                    last_served <= gnt_port;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ack0   = ack_q[0];
    assign ack1   = ack_q[1];
    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: behavioural flash and requester models,
// a per-cycle data/command scoreboard, and hand-computed latency expectations.
module tb_flash_read_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, flush, fl_ready, fl_read_en, ack0, ack1, timeout_err;
    logic [23:0] addr0, addr1, fl_addr;
    logic [7:0]  rdata0, rdata1, fl_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          drop_wait = 0;
    int          low_len = 1;
    bit          flash_hang = 1'b0;
    bit          flash_abort = 1'b0;
    bit          model_on = 1'b0;
    int          rd_count = 0;
    logic [23:0] last_rd_addr = '0;
    logic [23:0] fl_cmd;
    logic [7:0]  exp_rdata0 = '0;
    logic [7:0]  exp_rdata1 = '0;
    logic        prev_rd = 1'b0;

    always #5 clk = ~clk;

    flash_read_arbiter #(.TIMEOUT_CYCLES(1023)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .flush      (flush),
        .fl_ready   (fl_ready),
        .fl_read_en (fl_read_en),
        .fl_addr    (fl_addr),
        .fl_rdata   (fl_rdata),
        .timeout_err(timeout_err)
    );

    // Contents of the flash array as seen by the model.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h010000) return 8'hA5;
        return a[23:16] ^ a[15:8] ^ a[7:0] ^ 8'h3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int port, input logic v, input logic [23:0] a);
        if (port == 0) begin
            req0  = v;
            addr0 = a;
        end else begin
            req1  = v;
            addr1 = a;
        end
    endtask

    // Raise a request, hold it until n_acks acks are seen, then drop it.
    // Latency k = number of cycles from the request cycle (k=0) to the ack cycle.
    task automatic request(input int port, input logic [23:0] a, input int n_acks, input int budget,
                           output int lat_first, output int lat_last);
        int   got;
        int   k;
        logic ack_now;
        got       = 0;
        k         = 0;
        lat_first = -1;
        lat_last  = -1;
        drive_req(port, 1'b1, a);
        while (got < n_acks && k < budget) begin
            @(negedge clk);
            ack_now = (port == 0) ? ack0 : ack1;
            if (ack_now) begin
                got++;
                if (got == 1) lat_first = k;
                lat_last = k;
            end
            k++;
        end
        @(posedge clk);
        #1;
        drive_req(port, 1'b0, a);
        check($sformatf("ack_count_port%0d", port), got, n_acks);
    endtask

    // Flash controller: ready drops drop_wait+1 cycles after the command, stays
    // low for low_len cycles (or until released), then returns with data.
    initial begin
        fl_ready = 1'b1;
        fl_rdata = '0;
        forever begin
            @(negedge clk);
            if (fl_read_en === 1'b1 && reset === 1'b0) begin
                fl_cmd = fl_addr;
                repeat (drop_wait) @(posedge clk);
                @(posedge clk);
                #1 fl_ready = 1'b0;
                for (int k = 0; (k < low_len || flash_hang) && !flash_abort; k++) @(posedge clk);
                #1;
                fl_ready    = 1'b1;
                fl_rdata    = mem_byte(fl_cmd);
                flash_abort = 1'b0;
            end
        end
    end

    // Scoreboard: every ack carries the flash byte for the held address, rdata
    // holds the last acked byte, commands are single pulses for a live request.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_rdata0 = '0;
                exp_rdata1 = '0;
                prev_rd    = 1'b0;
            end else if (model_on) begin
                if (ack0) begin
                    check("ack0_with_req", req0, 1'b1);
                    exp_rdata0 = mem_byte(addr0);
                end
                if (ack1) begin
                    check("ack1_with_req", req1, 1'b1);
                    exp_rdata1 = mem_byte(addr1);
                end
                check("rdata0_model", rdata0, exp_rdata0);
                check("rdata1_model", rdata1, exp_rdata1);
                if (fl_read_en) begin
                    check("read_en_single_pulse", prev_rd, 1'b0);
                    check("fl_addr_requested",
                          (req0 && fl_addr == addr0) || (req1 && fl_addr == addr1), 1'b1);
                    rd_count++;
                    last_rd_addr = fl_addr;
                end
                prev_rd = fl_read_en;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int la, lb, l0, l1, rd0, acks, kt, lt, lh, dummy;
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        flush = 1'b0;
        repeat (3) tick();

        // Reset values
        @(negedge clk);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_fl_read_en", fl_read_en, 1'b0);
        check("rst_fl_addr", fl_addr, 24'h0);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_rdata1", rdata1, 8'h00);
        check("rst_timeout_err", timeout_err, 1'b0);
        tick();
        reset    = 1'b0;
        model_on = 1'b1;
        tick();

        // First tie after reset goes to port 0; fastest flash gives 4-cycle latency
        drop_wait = 0;
        low_len   = 1;
        rd0       = rd_count;
        fork
            request(0, 24'h020000, 1, 40, l0, dummy);
            request(1, 24'h030000, 1, 40, l1, dummy);
        join
        check("pairA_lat_port0", l0, 4);
        check("pairA_lat_port1", l1, 9);
        check("pairA_reads", rd_count - rd0, 2);
        check("pairA_rdata0", rdata0, 8'h3E);
        check("pairA_rdata1", rdata1, 8'h3F);

        // Slow flash read of 0x010000, request held through a second (hit) ack
        drop_wait = 1;
        low_len   = 10;
        rd0       = rd_count;
        request(0, 24'h010000, 2, 60, la, lb);
        check("miss_lat_0x010000", la, 14);
        check("held_hit_lat", lb, 16);
        check("miss_reads", rd_count - rd0, 1);
        check("miss_fl_addr", last_rd_addr, 24'h010000);
        check("miss_rdata0", rdata0, 8'hA5);
        check("fl_addr_held", fl_addr, 24'h010000);

        // Hits on both ports in the same cycle, no flash access
        drop_wait = 0;
        low_len   = 1;
        rd0       = rd_count;
        fork
            request(0, 24'h010000, 1, 10, l0, dummy);
            request(1, 24'h030000, 1, 10, l1, dummy);
        join
        check("dual_hit_lat0", l0, 1);
        check("dual_hit_lat1", l1, 1);
        check("dual_hit_reads", rd_count - rd0, 0);

        // Flush, then a miss whose capture coincides with another flush
        rd0   = rd_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fork
            request(1, 24'h030000, 1, 20, l1, dummy);
            begin
                repeat (3) tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
        join
        check("flush_miss_lat1", l1, 4);
        request(1, 24'h030000, 1, 10, l1, dummy);
        check("capture_beats_flush_hit", l1, 1);
        check("flush_port1_reads", rd_count - rd0, 1);

        // Flushed 0x010000 on port 0 is re-read
        rd0 = rd_count;
        request(0, 24'h010000, 1, 20, l0, dummy);
        check("reread_lat", l0, 4);
        check("reread_reads", rd_count - rd0, 1);
        check("reread_rdata0", rdata0, 8'hA5);

        // Port 0 served last, so this tie goes to port 1
        rd0 = rd_count;
        fork
            request(0, 24'h040000, 1, 40, l0, dummy);
            request(1, 24'h050000, 1, 40, l1, dummy);
        join
        check("pairB_lat_port1", l1, 4);
        check("pairB_lat_port0", l0, 9);
        check("pairB_reads", rd_count - rd0, 2);
        check("pairB_rdata0", rdata0, 8'h38);
        check("pairB_rdata1", rdata1, 8'h39);

        // Flash never returns: timeout, stall with ready low, hit still served, retry
        flash_hang = 1'b1;
        rd0        = rd_count;
        fork
            request(0, 24'h060000, 1, 1400, lt, dummy);
            begin
                bit seen;
                seen = 1'b0;
                kt   = 0;
                while (!seen && kt < 1200) begin
                    @(negedge clk);
                    if (timeout_err) seen = 1'b1;
                    else kt++;
                end
                check("timeout_cycle", kt, 1025);
                check("timeout_reads", rd_count - rd0, 1);
                @(posedge clk);
                #1;
                request(1, 24'h050000, 1, 10, lh, dummy);
                check("stall_hit_lat", lh, 1);
                check("stall_no_grant", rd_count - rd0, 1);
                drop_wait   = 0;
                low_len     = 1;
                flash_hang  = 1'b0;
                flash_abort = 1'b1;
            end
        join
        check("retry_after_timeout", lt > 1025, 1'b1);
        check("retry_reads", rd_count - rd0, 2);
        check("retry_fl_addr", last_rd_addr, 24'h060000);
        check("retry_rdata0", rdata0, 8'h3A);
        check("timeout_sticky", timeout_err, 1'b1);

        // Reset while waiting for flash data: request abandoned
        flash_hang = 1'b1;
        rd0        = rd_count;
        drive_req(1, 1'b1, 24'h070000);
        repeat (5) tick();
        reset = 1'b1;
        drive_req(1, 1'b0, 24'h070000);
        tick();
        reset       = 1'b0;
        flash_hang  = 1'b0;
        flash_abort = 1'b1;
        @(negedge clk);
        check("midrst_ack0", ack0, 1'b0);
        check("midrst_ack1", ack1, 1'b0);
        check("midrst_fl_read_en", fl_read_en, 1'b0);
        check("midrst_fl_addr", fl_addr, 24'h0);
        check("midrst_rdata0", rdata0, 8'h00);
        check("midrst_rdata1", rdata1, 8'h00);
        check("midrst_timeout_err", timeout_err, 1'b0);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        check("midrst_no_ack", acks, 0);
        check("midrst_reads", rd_count - rd0, 1);
        @(posedge clk);
        #1;

        // Hit valids were cleared by reset
        request(0, 24'h040000, 1, 20, l0, dummy);
        check("post_reset_miss_lat", l0, 4);
        check("post_reset_rdata0", rdata0, 8'h38);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
